// File: rtl/arm_pipe_pkg.sv
// Shared types and widths for the ARM pipeline control slice.
package arm_pipe_pkg;

  localparam int REG_W  = 4;
  localparam int WAIT_W = 8;

  typedef logic [REG_W-1:0] reg_tag_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pctl_state_t;

  // A source operand collides with a producer only if that producer writes back.
  function automatic logic tag_match(input logic wb_en, input reg_tag_t src, input reg_tag_t dest);
    return wb_en & (src == dest);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode/EXE/MEM observation bus and pipeline-control outputs of pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  import arm_pipe_pkg::*;

  logic             id_valid;
  reg_tag_t         id_src1;
  reg_tag_t         id_src2;
  logic             id_two_src;
  reg_tag_t         exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  reg_tag_t         mem_dest;
  logic             mem_wb_en;
  logic             fwd_en;
  logic             exe_branch;
  logic             mem_req;
  logic             mem_ready;

  logic             hazard_stall;
  logic             if_flush;
  logic             id_flush;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, fwd_en, exe_branch, mem_req, mem_ready,
    input  hazard_stall, if_flush, id_flush, pipe_freeze, mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, fwd_en, exe_branch, mem_req, mem_ready,
    output hazard_stall, if_flush, id_flush, pipe_freeze, mem_timeout, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_detect.sv
// Register-tag comparison between the ID operands and the EXE/MEM destinations.
module hazard_detect
  import arm_pipe_pkg::*;
(
  input  logic     id_valid_i,
  input  reg_tag_t id_src1_i,
  input  reg_tag_t id_src2_i,
  input  logic     id_two_src_i,
  input  reg_tag_t exe_dest_i,
  input  logic     exe_wb_en_i,
  input  logic     exe_mem_read_i,
  input  reg_tag_t mem_dest_i,
  input  logic     mem_wb_en_i,
  input  logic     fwd_en_i,
  output logic     raw_hazard_o
);

  logic exe_hit;
  logic mem_hit;

  assign exe_hit = tag_match(exe_wb_en_i, id_src1_i, exe_dest_i)
                 | (id_two_src_i & tag_match(exe_wb_en_i, id_src2_i, exe_dest_i));
  assign mem_hit = tag_match(mem_wb_en_i, id_src1_i, mem_dest_i)
                 | (id_two_src_i & tag_match(mem_wb_en_i, id_src2_i, mem_dest_i));

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign raw_hazard_o = id_valid_i & (fwd_en_i ? (exe_mem_read_i & exe_hit)
                                               : (exe_hit | mem_hit));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard stall / branch flush / memory-wait control with timeout-to-halt and
// saturating stall and flush event counters.
module pipeline_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  pctl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic raw_hazard;
  logic mem_stall;
  logic hazard_stall;
  logic if_flush;
  logic id_flush;
  logic pipe_freeze;

  hazard_detect u_hazard_detect (
    .id_valid_i     (bus.id_valid),
    .id_src1_i      (bus.id_src1),
    .id_src2_i      (bus.id_src2),
    .id_two_src_i   (bus.id_two_src),
    .exe_dest_i     (bus.exe_dest),
    .exe_wb_en_i    (bus.exe_wb_en),
    .exe_mem_read_i (bus.exe_mem_read),
    .mem_dest_i     (bus.mem_dest),
    .mem_wb_en_i    (bus.mem_wb_en),
    .fwd_en_i       (bus.fwd_en),
    .raw_hazard_o   (raw_hazard)
  );

  assign mem_stall = bus.mem_req & ~bus.mem_ready;

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready || !bus.mem_req) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d       = HALT;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // A frozen pipeline suppresses stall/flush; they re-evaluate once it is released.
  always_comb begin
    pipe_freeze  = 1'b0;
    hazard_stall = 1'b0;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    if (!rst) begin
      pipe_freeze = (state_q == HALT) | mem_stall;
      if (!pipe_freeze) begin
        if (bus.exe_branch) begin
          if_flush = 1'b1;
          id_flush = 1'b1;
        end else if (raw_hazard) begin
          hazard_stall = 1'b1;
          id_flush     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (if_flush && (flush_cnt_q != '1))     flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.hazard_stall = hazard_stall;
  assign bus.if_flush     = if_flush;
  assign bus.id_flush     = id_flush;
  assign bus.pipe_freeze  = pipe_freeze;
  assign bus.mem_timeout  = mem_timeout_q;
  assign bus.stall_count  = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Two controller instances (timeout 8 / 16-bit counters, timeout 4 / 2-bit counters)
// share one stimulus stream and are compared against a behavioural model.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
  logic       fwd_en, exe_branch, mem_req, mem_ready;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(16)) bus_a ();
  pipeline_ctrl_if #(.CNT_W(2))  bus_b ();

  pipeline_ctrl #(.MEM_TIMEOUT(8), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.id_valid = id_valid;         assign bus_b.id_valid = id_valid;
  assign bus_a.id_src1 = id_src1;           assign bus_b.id_src1 = id_src1;
  assign bus_a.id_src2 = id_src2;           assign bus_b.id_src2 = id_src2;
  assign bus_a.id_two_src = id_two_src;     assign bus_b.id_two_src = id_two_src;
  assign bus_a.exe_dest = exe_dest;         assign bus_b.exe_dest = exe_dest;
  assign bus_a.exe_wb_en = exe_wb_en;       assign bus_b.exe_wb_en = exe_wb_en;
  assign bus_a.exe_mem_read = exe_mem_read; assign bus_b.exe_mem_read = exe_mem_read;
  assign bus_a.mem_dest = mem_dest;         assign bus_b.mem_dest = mem_dest;
  assign bus_a.mem_wb_en = mem_wb_en;       assign bus_b.mem_wb_en = mem_wb_en;
  assign bus_a.fwd_en = fwd_en;             assign bus_b.fwd_en = fwd_en;
  assign bus_a.exe_branch = exe_branch;     assign bus_b.exe_branch = exe_branch;
  assign bus_a.mem_req = mem_req;           assign bus_b.mem_req = mem_req;
  assign bus_a.mem_ready = mem_ready;       assign bus_b.mem_ready = mem_ready;

  // Reference model: per instance, halted flag, consecutive frozen cycles, counts.
  bit m_halt [2];
  int m_run  [2];
  bit m_tmo  [2];
  int m_sc   [2];
  int m_fc   [2];

  function automatic int mt(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int cmax(input int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  function automatic bit raw_hz();
    bit e1, e2, m1, m2;
    e1 = exe_wb_en && (id_src1 == exe_dest);
    e2 = id_two_src && exe_wb_en && (id_src2 == exe_dest);
    m1 = mem_wb_en && (id_src1 == mem_dest);
    m2 = id_two_src && mem_wb_en && (id_src2 == mem_dest);
    if (!id_valid) return 1'b0;
    if (fwd_en) return exe_mem_read && (e1 || e2);
    return e1 || e2 || m1 || m2;
  endfunction

  // Expected {hazard_stall, if_flush, id_flush, pipe_freeze} for instance i.
  function automatic logic [3:0] exp_outs(input int i);
    bit frz, brn, hs;
    if (rst) return 4'b0000;
    frz = m_halt[i] || (mem_req && !mem_ready);
    brn = !frz && exe_branch;
    hs  = !frz && !exe_branch && raw_hz();
    return {hs, brn, brn || hs, frz};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input int i, input string nm, input logic hs, input logic ifl,
                           input logic idf, input logic frz, input logic tmo,
                           input logic [31:0] sc, input logic [31:0] fc);
    logic [3:0] e;
    e = exp_outs(i);
    check({nm, ".hazard_stall"}, {31'd0, hs},  {31'd0, e[3]});
    check({nm, ".if_flush"},     {31'd0, ifl}, {31'd0, e[2]});
    check({nm, ".id_flush"},     {31'd0, idf}, {31'd0, e[1]});
    check({nm, ".pipe_freeze"},  {31'd0, frz}, {31'd0, e[0]});
    check({nm, ".mem_timeout"},  {31'd0, tmo}, {31'd0, m_tmo[i]});
    check({nm, ".stall_count"},  sc, m_sc[i]);
    check({nm, ".flush_count"},  fc, m_fc[i]);
  endtask

  task automatic sample();
    check_dut(0, "a", bus_a.hazard_stall, bus_a.if_flush, bus_a.id_flush, bus_a.pipe_freeze,
              bus_a.mem_timeout, 32'(bus_a.stall_count), 32'(bus_a.flush_count));
    check_dut(1, "b", bus_b.hazard_stall, bus_b.if_flush, bus_b.id_flush, bus_b.pipe_freeze,
              bus_b.mem_timeout, 32'(bus_b.stall_count), 32'(bus_b.flush_count));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_halt[i] = 1'b0; m_run[i] = 0; m_tmo[i] = 1'b0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] e;
    if (rst) return;
    for (int i = 0; i < 2; i++) begin
      e = exp_outs(i);
      if (e[3] && m_sc[i] < cmax(i)) m_sc[i]++;
      if (e[2] && m_fc[i] < cmax(i)) m_fc[i]++;
      if (!m_halt[i]) begin
        if (mem_req && !mem_ready) begin
          m_run[i]++;
          if (m_run[i] == mt(i)) begin
            m_halt[i] = 1'b1;
            m_tmo[i]  = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_read = 0; mem_wb_en = 0;
    fwd_en = 0; exe_branch = 0; mem_req = 0; mem_ready = 0;
    id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
  endtask

  // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asserted mid-cycle with whatever inputs are present; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1 sample();
    @(negedge clk);
    sample();
    rst = 1'b0;
    clear_inputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};
  bit slow;

  initial begin
    clear_inputs();
    model_reset();
    id_valid = 1; id_src1 = 2; exe_dest = 2; exe_wb_en = 1; exe_branch = 1; mem_req = 1;
    do_reset();

    // Load-use with forwarding, then the same with a non-load producer.
    fwd_en = 1; exe_mem_read = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3; id_valid = 1;
    cycle();
    check("loaduse.stall_count", 32'(bus_a.stall_count), 32'd1);
    exe_mem_read = 0;
    cycle();

    // Forwarding off, MEM match on src2 only.
    clear_inputs();
    mem_wb_en = 1; mem_dest = 7; id_src2 = 7; id_src1 = 1; id_valid = 1;
    cycle();
    id_two_src = 1;
    cycle();

    // Branch coinciding with that hazard.
    exe_branch = 1;
    cycle();
    check("branch.flush_count", 32'(bus_a.flush_count), 32'd1);
    check("branch.stall_count", 32'(bus_a.stall_count), 32'd2);

    // Three-cycle memory wait with a branch pending throughout.
    mem_req = 1; mem_ready = 0;
    repeat (3) cycle();
    mem_ready = 1;
    cycle();
    mem_req = 0; mem_ready = 0; exe_branch = 0;
    cycle();

    // Saturation of the 2-bit counters.
    do_reset();
    fwd_en = 0; exe_wb_en = 1; exe_dest = 5; id_src1 = 5; id_valid = 1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("sat.stall_count_b", 32'(bus_b.stall_count), 32'(sat_exp[k]));
    end

    // Timeout: instance b halts after 4 frozen cycles, instance a after 8.
    clear_inputs();
    mem_req = 1; mem_ready = 0;
    repeat (4) cycle();
    check("timeout.b", {31'd0, bus_b.mem_timeout}, 32'd1);
    check("timeout.a_not_yet", {31'd0, bus_a.mem_timeout}, 32'd0);
    repeat (4) cycle();
    check("timeout.a", {31'd0, bus_a.mem_timeout}, 32'd1);
    mem_ready = 1;
    cycle();
    do_reset();

    // Randomized traffic with occasional slow memory and resets.
    slow = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) slow = ($urandom_range(0, 1) == 1);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_src1      = 4'($urandom_range(0, 3));
      id_src2      = 4'($urandom_range(0, 3));
      id_two_src   = 1'($urandom_range(0, 1));
      exe_dest     = 4'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_read = 1'($urandom_range(0, 1));
      mem_dest     = 4'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom_range(0, 1));
      fwd_en       = 1'($urandom_range(0, 1));
      exe_branch   = ($urandom_range(0, 5) == 0);
      if (!mem_req) mem_req = ($urandom_range(0, 3) == 0);
      else if (mem_ready || $urandom_range(0, 15) == 0) mem_req = ($urandom_range(0, 1) == 0);
      mem_ready = mem_req && ($urandom_range(0, slow ? 15 : 1) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard, flush and memory-wait controller for the 5-stage ARM pipeline. It watches the decode operands, the EXE/MEM destination tags and the data-memory handshake. It drives the freeze/flush controls of PC, IF/ID and ID/EX (the ID/EX register's `flush` input comes from here). It also owns a memory-wait state machine with a timeout-to-halt, plus saturating stall and flush performance counters.

## Interface
- `MEM_TIMEOUT`, default 15: consecutive frozen cycles before halt; legal range 2 to 2^8-1.
- `CNT_W`, default 16: width of the performance counters.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_src1`, `id_src2`  in  4 each  source registers of the ID instruction.
- `id_two_src`  in  1  the instruction actually reads `id_src2`.
- `exe_dest`  in  4  destination register in EXE.
- `exe_wb_en`, `exe_mem_read`  in  1 each  EXE write-back enable and load flag.
- `mem_dest`  in  4  destination register in MEM.
- `mem_wb_en`  in  1  MEM write-back enable.
- `fwd_en`  in  1  the forwarding unit is active.
- `exe_branch`  in  1  a taken branch is resolving in EXE.
- `mem_req`  in  1  the MEM stage is issuing a load or store.
- `mem_ready`  in  1  data memory has completed the access.
- `hazard_stall`  out  1  hold the PC and IF/ID.
- `if_flush`  out  1  clear IF/ID.
- `id_flush`  out  1  clear ID/EX (insert a bubble).
- `pipe_freeze`  out  1  hold every pipeline register and the PC.
- `mem_timeout`  out  1  sticky error: the memory did not respond.
- `stall_count`  out  `CNT_W`  number of data-hazard stall cycles.
- `flush_count`  out  `CNT_W`  number of branch flush events.

## Operation
- **Match definitions.**
  - `m_exe(s)` = `exe_wb_en` and `s == exe_dest`.
  - `m_mem(s)` = `mem_wb_en` and `s == mem_dest`.
  - The `src2` term is used only when `id_two_src = 1`.
- **Raw hazard.**
  - When `fwd_en = 0`: `id_valid` and (`m_exe` or `m_mem`) on `src1`, or on `src2` when used.
  - When `fwd_en = 1`: `id_valid` and `exe_mem_read` and `m_exe` on `src1`, or on `src2` when used. This is the load-use case only.
- **Freeze.** `pipe_freeze = (state == HALT) | (mem_req & ~mem_ready)`.
- **Output priority, highest first:**
  1. `pipe_freeze = 1`: `hazard_stall`, `if_flush` and `id_flush` are all 0. The frozen pipeline re-evaluates them on release.
  2. `exe_branch = 1`: `if_flush = id_flush = 1` and `hazard_stall = 0`. The branch kills the stalled instruction.
  3. Raw hazard: `hazard_stall = 1` and `id_flush = 1`.
  4. Otherwise all three are 0.
- **FSM states:** RUN, MEM_WAIT, HALT.
  - RUN: if `mem_req & ~mem_ready`, go to MEM_WAIT and set `wait_cnt = 1`.
  - MEM_WAIT, `mem_ready = 1`: return to RUN and clear `wait_cnt`.
  - MEM_WAIT, `mem_req` dropped: treat as an abort; return to RUN and clear `wait_cnt`.
  - MEM_WAIT, still waiting with `wait_cnt == MEM_TIMEOUT-1`: go to HALT and set `mem_timeout = 1`.
  - MEM_WAIT, still waiting otherwise: increment `wait_cnt`.
  - HALT: absorbing. `mem_ready` and `mem_req` are ignored; only `rst` exits.
- **Counters.**
  - `stall_count` increments by 1 on each edge where `hazard_stall` is 1.
  - `flush_count` increments by 1 on each edge where `if_flush` is 1.
  - Both saturate at all-ones and never wrap.
  - `wait_cnt` is internal and 8 bits wide.

## Timing
- `hazard_stall`, `if_flush`, `id_flush` and `pipe_freeze` are combinational from the inputs and `state`. They take effect in the same cycle, with zero latency.
- `state`, `wait_cnt`, `mem_timeout` and both counters are registered on the `clk` rising edge.
- **Reset values** (on `rst` assertion, asynchronous):
  - `state` = RUN, `wait_cnt` = 0, `mem_timeout` = 0, `stall_count` = 0, `flush_count` = 0.
  - While `rst = 1`, all combinational outputs are forced to 0.
- **Memory handshake.**
  - `mem_ready` in the same cycle as `mem_req` means zero freeze cycles.
  - N cycles of `mem_ready = 0` means exactly N frozen cycles.
- **Halt timing.** HALT is entered on the edge that ends the `MEM_TIMEOUT`-th consecutive frozen cycle. `mem_timeout` is visible starting the next cycle.
- **Reset mid-operation.** Reset during MEM_WAIT or HALT returns the block to RUN immediately. The counters are lost.

## Structure
- Shared package `arm_pipe_pkg`:
  - state enum `pctl_state_t` (RUN, MEM_WAIT, HALT);
  - `REG_W = 4`;
  - `WAIT_W = 8`.
- Combinational sub-module `hazard_detect`: register-tag comparisons and the `fwd_en` selection, producing the raw hazard.
- The top level holds the FSM, the output priority logic and the counters.

## Test plan
- **Load-use with forwarding.**
  - Stimulus: `fwd_en=1`, `exe_mem_read=1`, `exe_wb_en=1`, `exe_dest=3`, `id_src1=3`, `id_valid=1`.
  - Response: `hazard_stall=1`, `id_flush=1`; `stall_count` goes 0→1 at the next edge.
  - With `exe_mem_read=0`: no stall.
- **Forwarding off, MEM-stage match on src2.**
  - Stimulus: `fwd_en=0`, `mem_wb_en=1`, `mem_dest=7`, `id_src2=7`.
  - Response: no stall with `id_two_src=0`; `hazard_stall=1` with `id_two_src=1`.
- **Branch coinciding with a hazard.**
  - Response: `if_flush=id_flush=1`, `hazard_stall=0`; `flush_count` increments by 1 and `stall_count` is unchanged.
- **Memory wait of 3 cycles (`MEM_TIMEOUT=8`).**
  - Stimulus: `mem_ready` low for 3 cycles; `exe_branch=1` during the wait.
  - Response: `pipe_freeze` is high for exactly 3 cycles and both flushes stay 0. The block returns to RUN and `mem_timeout` stays 0.
- **Timeout (`MEM_TIMEOUT=4`).**
  - Stimulus: `mem_req=1` with `mem_ready=0` for 4 cycles.
  - Response: HALT and `mem_timeout=1`. A later `mem_ready=1` keeps `pipe_freeze=1`.
  - Then asynchronous `rst` mid-cycle: all outputs read 0 immediately.
- **Saturation (`CNT_W=2`).**
  - Stimulus: 5 consecutive hazard cycles.
  - Response: `stall_count` reads 1, 2, 3, 3, 3.
